// File: rtl/inv_stim_sequencer_pkg.sv
// Shared definitions for the inverter stimulus sequencer: the state
// encoding, the LFSR polynomial and seed, and the synchronizer depth.
package inv_seq_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRIVE  = 3'd1,
        SETTLE = 3'd2,
        SAMPLE = 3'd3,
        DONE   = 3'd4
    } state_e;

    // x^8 + x^6 + x^5 + x^4 + 1 as a left-shifting Fibonacci register:
    // the feedback is the XOR of bits 7, 5, 4 and 3.
    localparam logic [7:0] LFSR_TAPS   = 8'hB8;
    localparam logic [7:0] LFSR_SEED   = 8'h01;
    localparam int         SYNC_STAGES = 2;

    // One LFSR step: shift left, feedback enters at bit 0.
    function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
        return {cur[6:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/inv_stim_sequencer_sync2.sv
// Two-flop synchronizer (SYNC_STAGES deep) for one asynchronous input bit.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;
    logic meta_d;
    logic sync_d;

    // Next-state of the synchronizer chain.
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // Synchronizer flops, cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/inv_stim_sequencer.sv
// Inverter stimulus sequencer: drives NUM_VEC test bits onto an external
// inverter, samples its output after a programmable settle time and counts
// mismatches. Macro INV_SEQ_LFSR_EN selects LFSR stimulus; otherwise the
// stimulus is an alternating 1,0,1,0,... pattern.
module inv_stim_sequencer
    import inv_seq_pkg::*;
#(
    parameter int NUM_VEC = 64,
    parameter int ERR_W   = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam logic [7:0] LAST_IDX = 8'(NUM_VEC - 1);

    logic start_s;
    logic dut_s;
    logic start_edge_s;

    state_e             state_q,      state_d;
    logic [ERR_W-1:0]   err_cnt_q,    err_cnt_d;
    logic [7:0]         vec_idx_q,    vec_idx_d;
    logic [4:0]         cnt_q,        cnt_d;
    logic [3:0]         settle_q,     settle_d;
    logic               inv_q,        inv_d;
    logic               stim_q,       stim_d;
    logic               done_q,       done_d;
    logic               pass_q,       pass_d;
    logic               busy_q,       busy_d;
    logic               start_prev_q, start_prev_d;
`ifdef INV_SEQ_LFSR_EN
    logic [7:0]         lfsr_q,       lfsr_d;
`endif

    logic unused_s;
    assign unused_s = ^{ena, uio_in, ui_in[3]};

    sync2 u_sync_start (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (ui_in[0]),
        .q     (start_s)
    );

    sync2 u_sync_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (ui_in[2]),
        .q     (dut_s)
    );

    assign start_edge_s = start_s & ~start_prev_q;

    // Sequencer next-state and datapath updates.
    always_comb begin
        state_d      = state_q;
        err_cnt_d    = err_cnt_q;
        vec_idx_d    = vec_idx_q;
        cnt_d        = cnt_q;
        settle_d     = settle_q;
        inv_d        = inv_q;
        stim_d       = stim_q;
        done_d       = done_q;
        pass_d       = pass_q;
        start_prev_d = start_s;
`ifdef INV_SEQ_LFSR_EN
        lfsr_d       = lfsr_q;
`endif
        case (state_q)
            IDLE: begin
                if (start_edge_s) begin
                    err_cnt_d = '0;
                    vec_idx_d = 8'd0;
                    done_d    = 1'b0;
                    pass_d    = 1'b0;
                    inv_d     = ui_in[1];
                    settle_d  = ui_in[7:4];
`ifdef INV_SEQ_LFSR_EN
                    lfsr_d    = LFSR_SEED;
`endif
                    state_d   = DRIVE;
                end else begin
                    state_d   = IDLE;
                end
            end
            DRIVE: begin
`ifdef INV_SEQ_LFSR_EN
                stim_d = lfsr_q[0];
                lfsr_d = lfsr_next(lfsr_q);
`else
                if (vec_idx_q == 8'd0) begin
                    stim_d = 1'b1;
                end else begin
                    stim_d = ~stim_q;
                end
`endif
                cnt_d   = 5'd0;
                state_d = SETTLE;
            end
            SETTLE: begin
                // settle+2 cycles: the extra two cover the synchronizer.
                if (cnt_q == ({1'b0, settle_q} + 5'd1)) begin
                    state_d = SAMPLE;
                end else begin
                    cnt_d   = cnt_q + 5'd1;
                end
            end
            SAMPLE: begin
                if (dut_s != (stim_q ^ inv_q)) begin
                    if (err_cnt_q == {ERR_W{1'b1}}) begin
                        err_cnt_d = err_cnt_q;
                    end else begin
                        err_cnt_d = err_cnt_q + ERR_W'(1);
                    end
                end else begin
                    err_cnt_d = err_cnt_q;
                end
                if (vec_idx_q == LAST_IDX) begin
                    state_d   = DONE;
                end else begin
                    vec_idx_d = vec_idx_q + 8'd1;
                    state_d   = DRIVE;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                pass_d  = (err_cnt_q == '0);
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == DRIVE) || (state_d == SETTLE) || (state_d == SAMPLE);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            err_cnt_q    <= '0;
            vec_idx_q    <= 8'd0;
            cnt_q        <= 5'd0;
            settle_q     <= 4'd0;
            inv_q        <= 1'b0;
            stim_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            busy_q       <= 1'b0;
            start_prev_q <= 1'b0;
`ifdef INV_SEQ_LFSR_EN
            lfsr_q       <= LFSR_SEED;
`endif
        end else begin
            state_q      <= state_d;
            err_cnt_q    <= err_cnt_d;
            vec_idx_q    <= vec_idx_d;
            cnt_q        <= cnt_d;
            settle_q     <= settle_d;
            inv_q        <= inv_d;
            stim_q       <= stim_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            busy_q       <= busy_d;
            start_prev_q <= start_prev_d;
`ifdef INV_SEQ_LFSR_EN
            lfsr_q       <= lfsr_d;
`endif
        end
    end

    assign uo_out  = {4'b0000, pass_q, done_q, busy_q, stim_q};
    assign uio_out = 8'(err_cnt_q);
    assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_inv_stim_sequencer.sv
// Self-checking bench for inv_stim_sequencer: table-driven runs, random
// runs against a behavioural error model, plus reset and start corner cases.
module tb_inv_stim_sequencer;

    localparam int NV = 64;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_r;
    logic       inv_r;
    logic [3:0] settle_r;
    int         mode_r;      // 0 loopback, 1 inverted, 2 tied 0, 3 tied 1
    logic       dut_out_v;
    logic [7:0] ui_in, uo_out, uio_out, uio_oe;

    logic       start4;
    logic [7:0] ui4, uo4, uio4, oe4;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int mode;
        bit inv;
        int settle;
        int exp_err;
        bit exp_pass;
    } vec_t;

    vec_t tbl [7];

    always #5 clk = ~clk;

    always_comb begin
        case (mode_r)
            0:       dut_out_v = uo_out[0];
            1:       dut_out_v = ~uo_out[0];
            2:       dut_out_v = 1'b0;
            default: dut_out_v = 1'b1;
        endcase
    end

    assign ui_in = {settle_r, 1'b0, dut_out_v, inv_r, start_r};
    assign ui4   = {4'd0, 1'b0, ~uo4[0], 1'b0, start4};

    inv_stim_sequencer #(.NUM_VEC(NV), .ERR_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .ena(1'b1), .ui_in(ui_in), .uo_out(uo_out),
        .uio_in(8'h00), .uio_out(uio_out), .uio_oe(uio_oe)
    );

    inv_stim_sequencer #(.NUM_VEC(NV), .ERR_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .ena(1'b1), .ui_in(ui4), .uo_out(uo4),
        .uio_in(8'h00), .uio_out(uio4), .uio_oe(oe4)
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected error count: walk the stimulus sequence vector by vector.
    function automatic int model_err(input int mode, input bit inv, input int maxv);
        int       e = 0;
        bit       s;
        bit       d;
        bit [7:0] l = 8'h01;
        for (int k = 0; k < NV; k++) begin
`ifdef INV_SEQ_LFSR_EN
            s = l[0];
            l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
`else
            s = ((k % 2) == 0);
`endif
            case (mode)
                0:       d = s;
                1:       d = ~s;
                2:       d = 1'b0;
                default: d = 1'b1;
            endcase
            if (d != (s ^ inv)) e++;
        end
        return (e > maxv) ? maxv : e;
    endfunction

    // One run: raise start, count busy cycles. Optional mid-run scrambling of
    // invert_exp/settle, or holding start high with an extra mid-run pulse.
    task automatic do_run(input int mode, input bit inv, input int settle,
                          input bit scramble, input bit hold,
                          output int cyc, output bit ok);
        int n = 0;
        mode_r   = mode;
        inv_r    = inv;
        settle_r = 4'(settle);
        start_r  = 1'b1;
        ok       = 1'b1;
        cyc      = 0;
        while (!uo_out[1] && n < 20) begin
            step();
            n++;
        end
        if (!uo_out[1]) begin
            ok      = 1'b0;
            start_r = 1'b0;
            return;
        end
        if (!hold) start_r = 1'b0;
        while (uo_out[1] && cyc < 3000) begin
            cyc++;
            if (scramble && cyc == 7) begin
                inv_r    = 1'($urandom);
                settle_r = 4'($urandom);
            end
            if (hold && cyc == 50) start_r = 1'b0;
            if (hold && cyc == 53) start_r = 1'b1;
            step();
        end
        if (uo_out[1]) ok = 1'b0;
        step();
        step();
    endtask

    task automatic run_check(input string nm, input int mode, input bit inv,
                             input int settle, input bit scramble,
                             input int exp_err, input bit exp_pass);
        int cyc;
        bit ok;
        do_run(mode, inv, settle, scramble, 1'b0, cyc, ok);
        chk({nm, "_timeout"}, int'(ok), 1);
        chk({nm, "_cycles"}, cyc, NV * (settle + 4));
        chk({nm, "_done"}, int'(uo_out[2]), 1);
        chk({nm, "_pass"}, int'(uo_out[3]), int'(exp_pass));
        chk({nm, "_err"}, int'(uio_out), exp_err);
    endtask

    initial begin
        int  cyc;
        bit  ok;
        int  m;
        bit  iv;
        int  st;
        int  e;
        int  extra_busy;
        int  done_drop;
        int  n;

        tbl[0] = '{0, 1'b0, 0,  0,  1'b1};
        tbl[1] = '{1, 1'b1, 3,  0,  1'b1};
        tbl[2] = '{2, 1'b0, 1,  32, 1'b0};
        tbl[3] = '{3, 1'b0, 0,  32, 1'b0};
        tbl[4] = '{1, 1'b0, 2,  64, 1'b0};
        tbl[5] = '{0, 1'b1, 15, 64, 1'b0};
        tbl[6] = '{3, 1'b1, 0,  32, 1'b0};
`ifdef INV_SEQ_LFSR_EN
        foreach (tbl[i]) begin
            tbl[i].exp_err  = model_err(tbl[i].mode, tbl[i].inv, 255);
            tbl[i].exp_pass = (tbl[i].exp_err == 0);
        end
`endif

        rst_n = 1'b0; start_r = 1'b0; inv_r = 1'b0; settle_r = 4'd0;
        mode_r = 0; start4 = 1'b0;
        step();
        step();
        chk("rst_uo_out", int'(uo_out), 0);
        chk("rst_uio_out", int'(uio_out), 0);
        chk("rst_uio_oe", int'(uio_oe), 8'hFF);
        chk("rst_uo4", int'(uo4), 0);
        rst_n = 1'b1;
        step();
        step();

        foreach (tbl[i]) begin
            run_check($sformatf("tbl%0d", i), tbl[i].mode, tbl[i].inv,
                      tbl[i].settle, 1'b0, tbl[i].exp_err, tbl[i].exp_pass);
        end

        for (int r = 0; r < 5; r++) begin
            m  = $urandom_range(0, 3);
            iv = 1'($urandom);
            st = $urandom_range(0, 6);
            e  = model_err(m, iv, 255);
            run_check($sformatf("rnd%0d", r), m, iv, st, 1'b1, e, (e == 0));
        end

        // Saturating counter on the 4-bit instance.
        start4 = 1'b1;
        n = 0;
        while (!uo4[1] && n < 20) begin step(); n++; end
        start4 = 1'b0;
        n = 0;
        while (uo4[1] && n < 2000) begin step(); n++; end
        step();
        chk("sat_busy_cycles", n, NV * 4);
        chk("sat_uio_out", int'(uio4), model_err(1, 1'b0, 15));
        chk("sat_done", int'(uo4[2]), 1);
        chk("sat_pass", int'(uo4[3]), 0);
        chk("sat_upper_zero", int'(uo4[7:4]), 0);

        // Reset during vector 10, then a clean run.
        mode_r = 0; inv_r = 1'b0; settle_r = 4'd0; start_r = 1'b1;
        n = 0;
        while (!uo_out[1] && n < 20) begin step(); n++; end
        start_r = 1'b0;
        for (int k = 0; k < 10 * 4 + 2; k++) step();
        chk("mid_busy_before_reset", int'(uo_out[1]), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_uo_out", int'(uo_out), 0);
        chk("mid_rst_uio_out", int'(uio_out), 0);
        chk("mid_rst_uio_oe", int'(uio_oe), 8'hFF);
        step();
        step();
        rst_n = 1'b1;
        step(); step(); step();
        chk("post_rst_no_done", int'(uo_out), 0);
        run_check("post_rst", 0, 1'b0, 0, 1'b0, 0, 1'b1);

        // Start held high through DONE with an extra pulse mid-run.
        do_run(0, 1'b0, 1, 1'b0, 1'b1, cyc, ok);
        chk("hold_timeout", int'(ok), 1);
        chk("hold_cycles", cyc, NV * 5);
        extra_busy = 0;
        done_drop  = 0;
        for (int k = 0; k < 40; k++) begin
            if (uo_out[1]) extra_busy++;
            if (!uo_out[2]) done_drop++;
            step();
        end
        chk("hold_no_retrigger", extra_busy, 0);
        chk("hold_done_stable", done_drop, 0);
        chk("hold_pass", int'(uo_out[3]), 1);
        start_r = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/inv_stim_sequencer.md
INV_STIM_SEQUENCER -- requirements
Module: inv_stim_sequencer

Interface
REQ-001 SHALL have parameter NUM_VEC, default 64, vectors per run (legal 2..255).
REQ-002 SHALL have parameter ERR_W, default 8, error-counter width (legal 1..8; unused uio_out bits driven 0).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port ena  input  1  always 1 when powered; ignored.
REQ-006 SHALL have port ui_in  input  8  [0] start, [1] invert_exp, [2] dut_out (asynchronous, from inverter output), [3] unused, [7:4] settle.
REQ-007 SHALL have port uo_out  output  8  [0] stim (drives inverter input), [1] busy, [2] done, [3] pass, [7:4] 0.
REQ-008 SHALL have port uio_in  input  8  unused.
REQ-009 SHALL have port uio_out  output  8  error count, zero-extended.
REQ-010 SHALL have port uio_oe  output  8  constant 0xFF.

Function
REQ-011 SHALL pass ui_in[0] and ui_in[2] through 2-flop synchronizers, giving start_s and dut_s.
REQ-012 SHALL detect a start edge as start_s=1 while its previous-cycle value was 0.
REQ-013 SHALL implement states IDLE, DRIVE, SETTLE, SAMPLE, DONE.
REQ-014 IDLE: on start edge SHALL clear err_cnt, vec_idx, done, pass; latch invert_exp and settle; load stimulus seed; go to DRIVE.
REQ-015 DRIVE: SHALL last 1 cycle, update stim to the next stimulus bit, and go to SETTLE.
REQ-016 SETTLE: SHALL last exactly settle+2 cycles, covering synchronizer delay, then go to SAMPLE.
REQ-017 SAMPLE: SHALL last 1 cycle and compare dut_s with stim XOR invert_exp.
REQ-018 On SAMPLE mismatch SHALL increment err_cnt, saturating at all-ones.
REQ-019 In SAMPLE SHALL go to DONE if vec_idx==NUM_VEC-1; otherwise SHALL increment vec_idx and go to DRIVE.
REQ-020 Per-vector latency SHALL be settle+4 cycles; a run SHALL span NUM_VEC*(settle+4) cycles from DRIVE entry to DONE entry.
REQ-021 DONE: SHALL set done=1 and pass=(err_cnt==0), then go to IDLE.
REQ-022 done, pass, err_cnt and stim SHALL hold their values in IDLE until the next start edge.
REQ-023 busy SHALL be 1 exactly in DRIVE, SETTLE and SAMPLE.
REQ-024 Start edges while busy SHALL be ignored.
REQ-025 start held high SHALL NOT retrigger a run.
REQ-026 Changes of ui_in[1] or ui_in[7:4] during a run SHALL have no effect.

Reset
REQ-027 rst_n low SHALL asynchronously force IDLE; clear synchronizers, err_cnt, vec_idx and stim; and reset the LFSR to 0x01.
REQ-028 During reset SHALL drive uo_out=0x00, uio_out=0x00, uio_oe=0xFF.
REQ-029 Reset mid-run SHALL abort without setting done; the next start edge SHALL begin a clean run.

Configuration
REQ-030 Macro INV_SEQ_LFSR_EN defined: stimulus SHALL come from an 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1, seed 0x01); each DRIVE sets stim=lfsr[0] and then advances the LFSR.
REQ-031 Macro INV_SEQ_LFSR_EN undefined: stim SHALL be 1 for vector 0 and toggle each DRIVE; no LFSR logic SHALL be present.

Structure
REQ-032 Package inv_seq_pkg SHALL hold the state enum, LFSR taps, seed 0x01 and SYNC_STAGES=2.
REQ-033 Sub-module sync2 (2-flop synchronizer, async active-low reset) SHALL be instantiated for start and dut_out.

Verification
REQ-034 dut_out looped to stim, invert_exp=0, settle=0, NUM_VEC=64 -> done at cycle 256 after DRIVE entry, pass=1, uio_out=0x00.
REQ-035 dut_out = NOT stim, invert_exp=1, settle=3 -> 448-cycle run, pass=1, err=0.
REQ-036 INV_SEQ_LFSR_EN undefined, dut_out tied 0, invert_exp=0, NUM_VEC=64 -> err=32, pass=0.
REQ-037 ERR_W=4, dut_out = NOT stim, invert_exp=0 -> err saturates at 15, uio_out=0x0F, pass=0.
REQ-038 rst_n low during vector 10 -> uo_out=0x00 immediately; the next start edge gives a full 64-vector run.
REQ-039 start held high through DONE, plus a start pulse mid-run -> exactly one run, done=1 stays stable.
